alu_op_sequencer: RTL and testbench

- Control-side counterpart of the 32-bit ALU result multiplexer.
- Accepts an operation command, registers the operands and drives the 3-bit `sel` that the result mux consumes.
- Sequences the multi-cycle modulo unit with a start/done handshake, then captures the selected result and returns it with a one-cycle `done` pulse.
- Sits between the top-level ALU command interface and the functional units plus result mux.

---
 rtl/alu_op_sequencer.sv | 114 +++++++++++
 tb/tb_alu_op_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Control sequencer for the 32-bit ALU result mux: latches operands, drives sel, runs the modulo handshake.
// Optional flags outputs (flag_zero, flag_neg) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_op_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MOD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [2:0]       sel,
  output logic             mod_start,
  input  logic             mod_done,
  input  logic [WIDTH-1:0] result_in,
  output logic [WIDTH-1:0] result_out,
  output logic             done,
  output logic             busy,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             flag_zero,
  output logic             flag_neg,
`endif
  output logic             error
);

  localparam int              CW       = $clog2(MOD_TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MOD_TIMEOUT - 1);
  localparam logic [2:0]      OP_MOD   = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MOD_WAIT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            accept, mod_zero, mod_last, timeout;
  logic            load_result;
  logic [WIDTH-1:0] result_value;

  assign accept   = (state_reg == IDLE) && start;
  assign mod_zero = (opcode == OP_MOD) && (b == '0);
  assign mod_last = (cnt_reg == CNT_LAST);
  // mod_done in the final wait cycle takes priority over the timeout
  assign timeout  = (state_reg == MOD_WAIT) && !mod_done && mod_last;

  assign load_result  = (state_reg == EXEC) ||
                        ((state_reg == MOD_WAIT) && (mod_done || mod_last)) ||
                        (accept && mod_zero);
  assign result_value = ((state_reg == EXEC) || ((state_reg == MOD_WAIT) && mod_done))
                        ? result_in : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (opcode != OP_MOD) state_next = EXEC;
          else if (mod_zero)    state_next = DONE;
          else                  state_next = MOD_WAIT;
        end
      end
      EXEC:     state_next = DONE;
      MOD_WAIT: if (mod_done || mod_last) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    done      = (state_reg == DONE);
    busy      = (state_reg == EXEC) || (state_reg == MOD_WAIT);
    mod_start = (state_reg == MOD_WAIT) && (cnt_reg == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      sel        <= '0;
      result_out <= '0;
      error      <= 1'b0;
      cnt_reg    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_a    <= a;
        op_b    <= b;
        sel     <= opcode;
        error   <= mod_zero;
        cnt_reg <= '0;
      end else begin
        if (timeout) error <= 1'b1;
        if (state_reg == MOD_WAIT) cnt_reg <= cnt_reg + CW'(1);
      end
      if (load_result) begin
        result_out <= result_value;
`ifdef ALU_SEQ_FLAGS_EN
        flag_zero  <= (result_value == '0);
        flag_neg   <= result_value[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: randomized commands vs. a behavioural ALU/latency model.
module tb_alu_op_sequencer;
  localparam int W   = 32;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mod_done = 1'b0;
  logic [2:0]   opcode = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] result_in;
  logic [W-1:0] op_a, op_b, result_out;
  logic [2:0]   sel;
  logic         mod_start, done, busy, error;
`ifdef ALU_SEQ_FLAGS_EN
  logic         flag_zero, flag_neg;
`endif

  alu_op_sequencer #(.WIDTH(W), .MOD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
    .op_a(op_a), .op_b(op_b), .sel(sel), .mod_start(mod_start), .mod_done(mod_done),
    .result_in(result_in), .result_out(result_out), .done(done), .busy(busy),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_zero(flag_zero), .flag_neg(flag_neg),
`endif
    .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ms_count = 0;
  int ms_cyc = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         err;
    int           cyc_done;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return (x < y) ? 1 : 0;
      3'd5: return x + y;
      3'd6: return x - y;
      default: return (y == 0) ? 0 : x % y;
    endcase
  endfunction

  // Functional units + result mux stub
  always_comb result_in = ref_alu(sel, op_a, op_b);

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (rst_n && mod_start) begin
      ms_count++;
      ms_cyc = cyc;
    end
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] op=%0d result=%h err=%0b done_cycle=%0d", e.op, result_out, error, cyc);
        check("result_out", result_out, e.res);
        check("error", W'(error), W'(e.err));
        check("latency", W'(cyc), W'(e.cyc_done));
`ifdef ALU_SEQ_FLAGS_EN
        check("flag_zero", W'(flag_zero), W'(e.res == 0));
        check("flag_neg", W'(flag_neg), W'(e.res[W-1]));
`endif
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 1, 0);
  endtask

  // Issue one command from a negedge in IDLE. d = cycles from mod_start to mod_done (0 = never).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int d, input bit hold);
    exp_t e;
    int   t0;
    bit   exp_ms;
    t0 = cyc;
    start = 1; opcode = op; a = av; b = bv;
    ms_count = 0;
    e.op = op;
    exp_ms = 0;
    if (op != 3'd7) begin
      e.res = ref_alu(op, av, bv); e.err = 0; e.cyc_done = t0 + 2;
    end else if (bv == 0) begin
      e.res = 0; e.err = 1; e.cyc_done = t0 + 1;
    end else if (d > 0 && d <= TMO - 1) begin
      e.res = av % bv; e.err = 0; e.cyc_done = t0 + d + 2; exp_ms = 1;
    end else begin
      e.res = 0; e.err = 1; e.cyc_done = t0 + TMO + 1; exp_ms = 1;
    end
    sb.push_back(e);
    @(negedge clk);
    if (hold) begin
      opcode = 3'd0; a = ~av; b = $urandom;
    end else begin
      start = 0;
    end
    check("sel", W'(sel), W'(op));
    check("op_a", op_a, av);
    check("op_b", op_b, bv);
    if (hold) begin
      @(negedge clk);
      start = 0;
      check("sel_hold", W'(sel), W'(op));
      check("op_a_hold", op_a, av);
    end
    if (op == 3'd7 && bv != 0 && d > 0) begin
      while (cyc < t0 + 1 + d) @(negedge clk);
      mod_done = 1;
      @(negedge clk);
      mod_done = 0;
    end
    wait_idle();
    check("mod_start_count", W'(ms_count), W'(exp_ms));
    if (exp_ms) check("mod_start_cycle", W'(ms_cyc), W'(t0 + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    repeat (2) @(negedge clk);
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_mod_start", W'(mod_start), 0);
    check("reset_result", result_out, 0);
    check("reset_sel", W'(sel), 0);
    check("reset_error", W'(error), 0);
    rst_n = 1;
    @(negedge clk);

    run_op(3'd5, 5, 7, 0, 0);                 // add -> 12
    run_op(3'd7, 17, 5, 4, 0);                // mod via handshake -> 2
    run_op(3'd7, 17, 0, 0, 0);                // mod by zero
    run_op(3'd7, 9, 4, 0, 0);                 // timeout
    run_op(3'd1, 3, 4, 0, 0);                 // error cleared by next start
    run_op(3'd7, 100, 7, TMO - 1, 0);         // mod_done in the final wait cycle wins
    run_op(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1);  // start held while busy
    run_op(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);  // negative result

    // Reset during MOD_WAIT: everything returns to reset values, no done
    start = 1; opcode = 3'd7; a = 50; b = 3;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_busy", W'(busy), 0);
    check("midrst_mod_start", W'(mod_start), 0);
    check("midrst_done", W'(done), 0);
    check("midrst_op_a", op_a, 0);
    check("midrst_sel", W'(sel), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    run_op(3'd6, 40, 2, 0, 0);

    for (int i = 0; i < 60; i++) begin
      rop = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(1, 1000)));
      run_op(rop, ra, rb, $urandom_range(0, 10), $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
